// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle shift sequencer for the execute stage.
// One small fixed-step shift stage is reused across cycles instead of a
// full barrel shifter. The default build steps by 2 bits per cycle (1 for an
// odd remainder). Defining SHIFT_SEQ_STEP4_EN adds a 4-bit step.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (priority over flush)
//   flush      abort any in-flight op and return to idle; drops a same-cycle request
//   in_valid   request valid
//   in_ready   sequencer can accept a request (low while rst is high)
//   in_data    operand
//   in_op      00 SLL, 01 SRL, 10 SRA, 11 reserved (treated as SLL)
//   in_shamt   shift amount
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_data   shifted result (qualify with out_valid)
//   busy       high while shifting or holding a result
module shift_seq_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_op,
  input  logic [SHAMT_W-1:0]    in_shamt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] work_q;
  logic [SHAMT_W-1:0]    rem_q;
  logic [1:0]            op_q;
  logic                  out_valid_q;

  logic [SHAMT_W-1:0]    step;
  logic [DATA_WIDTH-1:0] work_shift;

  // Largest step that does not overshoot the remaining count.
  always_comb begin
    step = SHAMT_W'(1);
`ifdef SHIFT_SEQ_STEP4_EN
    if (rem_q >= SHAMT_W'(4)) begin
      step = SHAMT_W'(4);
    end else if (rem_q >= SHAMT_W'(2)) begin
      step = SHAMT_W'(2);
    end
`else
    if (rem_q >= SHAMT_W'(2)) begin
      step = SHAMT_W'(2);
    end
`endif
  end

  // SRA fills from the current MSB, which is the original sign at every step.
  always_comb begin
    work_shift = work_q << step;
    case (op_q)
      2'b01:   work_shift = work_q >> step;
      2'b10:   work_shift = $unsigned($signed(work_q) >>> step);
      default: work_shift = work_q << step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      work_q      <= '0;
      rem_q       <= '0;
      op_q        <= 2'b00;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      // Work register is deliberately left alone; nothing consumes it outside StDone.
      state_q     <= StIdle;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q <= in_data;
            op_q   <= in_op;
            rem_q  <= in_shamt;
            if (in_shamt == '0) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          work_q <= work_shift;
          rem_q  <= rem_q - step;
          if (rem_q == step) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_data  = work_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks;
  int errors;

`ifdef SHIFT_SEQ_STEP4_EN
  localparam int Lat31 = 10;
  localparam int Lat5  = 3;
  localparam int Lat4  = 2;
`else
  localparam int Lat31 = 17;
  localparam int Lat5  = 4;
  localparam int Lat4  = 3;
`endif

  shift_seq_ctrl #(
    .DATA_WIDTH(32),
    .SHAMT_W   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_op    (in_op),
    .in_shamt (in_shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge (caller checks in_ready first).
  task automatic issue(input logic [31:0] d, input logic [1:0] op, input logic [4:0] sh);
    in_valid = 1'b1;
    in_data  = d;
    in_op    = op;
    in_shamt = sh;
    tick();
    in_valid = 1'b0;
  endtask

  // Latency counted in edges, the accepting edge being 1; capped at 40.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    checks++;
    if (out_data !== 32'h0) begin
      errors++; $display("FAIL reset_out_data: got %h want 00000000", out_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_sll_basic();
    int lat;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL sll_ready: got %b want 1", in_ready);
    end
    issue(32'h0000_0001, 2'b00, 5'd2);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL sll_busy: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL sll_latency: got %0d want 2", lat);
    end
    checks++;
    if (out_data !== 32'h0000_0004) begin
      errors++; $display("FAIL sll_data: got %h want 00000004", out_data);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL sll_return_idle: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                         in_ready, out_valid, busy);
    end
  endtask

  task automatic test_shift_31();
    int lat;
    out_ready = 1'b1;
    issue(32'h8000_0000, 2'b10, 5'd31);
    wait_valid(lat);
    checks++;
    if (lat !== Lat31) begin
      errors++; $display("FAIL sra31_latency: got %0d want %0d", lat, Lat31);
    end
    checks++;
    if (out_data !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sra31_data: got %h want ffffffff", out_data);
    end
    tick();
    issue(32'h8000_0000, 2'b01, 5'd31);
    wait_valid(lat);
    checks++;
    if (lat !== Lat31 || out_data !== 32'h0000_0001) begin
      errors++; $display("FAIL srl31: lat=%0d data=%h want %0d 00000001", lat, out_data, Lat31);
    end
    tick();
  endtask

  task automatic test_srl_small();
    int lat;
    out_ready = 1'b1;
    issue(32'hF000_0000, 2'b01, 5'd0);
    wait_valid(lat);
    checks++;
    if (lat !== 1 || out_data !== 32'hF000_0000) begin
      errors++; $display("FAIL srl0: lat=%0d data=%h want 1 f0000000", lat, out_data);
    end
    tick();
    issue(32'hF000_0000, 2'b01, 5'd5);
    wait_valid(lat);
    checks++;
    if (lat !== Lat5 || out_data !== 32'h0780_0000) begin
      errors++; $display("FAIL srl5: lat=%0d data=%h want %0d 07800000", lat, out_data, Lat5);
    end
    tick();
  endtask

  task automatic test_ops_mix();
    int lat;
    out_ready = 1'b1;
    // Reserved op behaves as SLL.
    issue(32'h0000_0001, 2'b11, 5'd3);
    wait_valid(lat);
    checks++;
    if (out_data !== 32'h0000_0008) begin
      errors++; $display("FAIL reserved_op: got %h want 00000008", out_data);
    end
    tick();
    issue(32'h4000_0000, 2'b10, 5'd3);
    wait_valid(lat);
    checks++;
    if (out_data !== 32'h0800_0000) begin
      errors++; $display("FAIL sra_positive: got %h want 08000000", out_data);
    end
    tick();
    issue(32'h8000_0010, 2'b10, 5'd4);
    wait_valid(lat);
    checks++;
    if (out_data !== 32'hF800_0001) begin
      errors++; $display("FAIL sra_negative: got %h want f8000001", out_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    issue(32'h0000_00FF, 2'b00, 5'd4);
    wait_valid(lat);
    checks++;
    if (lat !== Lat4) begin
      errors++; $display("FAIL bp_latency: got %0d want %0d", lat, Lat4);
    end
    // Offer a competing request that must be ignored while the result is held.
    in_valid = 1'b1;
    in_data  = 32'h0000_1234;
    in_op    = 2'b00;
    in_shamt = 5'd0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h0000_0FF0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: out_valid=%b data=%h in_ready=%b want 1 00000ff0 0",
                           i, out_valid, out_data, in_ready);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b want 0 1 0",
                         out_valid, in_ready, busy);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_no_accept: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    out_ready = 1'b1;
    issue(32'h8000_0000, 2'b10, 5'd31);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle: in_ready=%b busy=%b out_valid=%b want 1 0 0",
                         in_ready, busy, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL flush_no_result: out_valid cycles=%0d want 0", seen);
    end
    // A request coinciding with flush is dropped.
    flush = 1'b1;
    issue(32'h0000_0001, 2'b00, 5'd0);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_drops_req: busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
    issue(32'h0000_0003, 2'b00, 5'd1);
    wait_valid(lat);
    checks++;
    if (lat !== 2 || out_data !== 32'h0000_0006) begin
      errors++; $display("FAIL flush_followup: lat=%0d data=%h want 2 00000006", lat, out_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    out_ready = 1'b1;
    issue(32'h8000_0000, 2'b10, 5'd31);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_in_ready: got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: out_valid=%b busy=%b data=%h in_ready=%b want 0 0 0 0",
                         out_valid, busy, out_data, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_release: in_ready=%b want 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid || busy) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL rst_mid_no_result: active cycles=%0d want 0", seen);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_op     = 2'b00;
    in_shamt  = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_sll_basic();
    test_shift_31();
    test_srl_small();
    test_ops_mix();
    test_backpressure();
    test_flush();
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
